// File: rtl/fold_pkg.sv
// Shared definitions for the fold-group sequencer: type bit positions,
// sequencer state encodings and fold-type qualification.
package fold_pkg;

  localparam int FT_NF  = 0;
  localparam int FT_LV  = 1;
  localparam int FT_MEM = 2;
  localparam int FT_BG1 = 3;
  localparam int FT_BG2 = 4;
  localparam int FT_BR  = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } fold_state_e;

  // An empty type, or one flagged NF, can never pair with anything.
  function automatic logic [5:0] fold_qual(input logic [5:0] t);
    logic nf;
    nf = (t == 6'd0) || t[FT_NF];
    return nf ? 6'b000001 : t;
  endfunction

endpackage

// File: rtl/fold_match.sv
// Combinational fold-group selector: largest matching pattern whose bytes
// are all present in the instruction buffer.
module fold_match
  import fold_pkg::*;
(
  input  logic [5:0] type_0,
  input  logic [5:0] type_1,
  input  logic [5:0] type_2,
  input  logic [5:0] type_3,
  input  logic [7:0] accum_len0,
  input  logic [7:0] accum_len1,
  input  logic [7:0] accum_len2,
  input  logic [7:0] accum_len3,
  input  logic [3:0] ibuf_cnt,
  input  logic       single_only,
  output logic [2:0] cand_cnt,
  output logic [7:0] cand_len
);

  logic [5:0] t0, t1, t2, t3;
  logic [7:0] fill;
  logic       av0, av1, av2, av3;
  logic       m2, m3, m4;

  always_comb begin
    t0   = fold_qual(type_0);
    t1   = fold_qual(type_1);
    t2   = fold_qual(type_2);
    t3   = fold_qual(type_3);
    fill = {4'd0, ibuf_cnt};

    av0 = accum_len0 <= fill;
    av1 = accum_len1 <= fill;
    av2 = accum_len2 <= fill;
    av3 = accum_len3 <= fill;

    m4 = t0[FT_LV] & t1[FT_LV] & t2[FT_BG2] & t3[FT_MEM];
    m3 = (t0[FT_LV] & t1[FT_LV]  & t2[FT_BG2])
       | (t0[FT_LV] & t1[FT_BG2] & t2[FT_MEM])
       | (t0[FT_LV] & t1[FT_BG1] & t2[FT_MEM])
       | (t0[FT_LV] & t1[FT_LV]  & t2[FT_BR]);
    m2 = (t0[FT_LV]  & (t1[FT_BG2] | t1[FT_BG1] | t1[FT_MEM] | t1[FT_BR]))
       | ((t0[FT_BG2] | t0[FT_BG1]) & t1[FT_MEM]);

    cand_cnt = 3'd0;
    if (!av0)                     cand_cnt = 3'd0;
    else if (single_only)         cand_cnt = 3'd1;
    else if (m4 && av3)           cand_cnt = 3'd4;
    else if (m3 && av2)           cand_cnt = 3'd3;
    else if (m2 && av1)           cand_cnt = 3'd2;
    else                          cand_cnt = 3'd1;

    case (cand_cnt)
      3'd1:    cand_len = accum_len0;
      3'd2:    cand_len = accum_len1;
      3'd3:    cand_len = accum_len2;
      3'd4:    cand_len = accum_len3;
      default: cand_len = 8'd0;
    endcase
  end

endmodule

// File: rtl/fold_ctl.sv
// Fold-group sequencer: issues fold groups to decode under hold/flush and
// forces single-instruction issue for SINGLE_CNT groups after a flush.
//
//   state      | meaning
//   ST_RUN     | normal issue, folding allowed
//   ST_FLUSH   | one-cycle bubble after a flush, recovery counter loaded
//   ST_RECOVER | single-instruction issue until rec_cnt reaches 0
module fold_ctl
  import fold_pkg::*;
#(
  parameter int SINGLE_CNT = 2
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       fold_en,
  input  logic [5:0] type_0,
  input  logic [5:0] type_1,
  input  logic [5:0] type_2,
  input  logic [5:0] type_3,
  input  logic [7:0] accum_len0,
  input  logic [7:0] accum_len1,
  input  logic [7:0] accum_len2,
  input  logic [7:0] accum_len3,
  input  logic [3:0] ibuf_cnt,
  input  logic       iu_hold,
  input  logic       iu_flush,
  output logic       ibuf_shift_en,
  output logic [7:0] ibuf_shift_len,
  output logic       grp_valid,
  output logic [2:0] grp_cnt,
  output logic [7:0] grp_len,
  output logic       grp_fold
);

  localparam logic [2:0] SINGLE_CNT_L = 3'(SINGLE_CNT);

  fold_state_e state_q, state_d;
  logic [2:0]  rec_cnt_q, rec_cnt_d;
  logic        grp_valid_q, grp_valid_d;
  logic [2:0]  grp_cnt_q, grp_cnt_d;
  logic [7:0]  grp_len_q, grp_len_d;
  logic        grp_fold_q, grp_fold_d;
  logic [2:0]  cand_cnt;
  logic [7:0]  cand_len;

  fold_match u_match (
    .type_0      (type_0),
    .type_1      (type_1),
    .type_2      (type_2),
    .type_3      (type_3),
    .accum_len0  (accum_len0),
    .accum_len1  (accum_len1),
    .accum_len2  (accum_len2),
    .accum_len3  (accum_len3),
    .ibuf_cnt    (ibuf_cnt),
    .single_only (!fold_en || (state_q == ST_RECOVER)),
    .cand_cnt    (cand_cnt),
    .cand_len    (cand_len)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_RUN;
      rec_cnt_q   <= 3'd0;
      grp_valid_q <= 1'b0;
      grp_cnt_q   <= 3'd0;
      grp_len_q   <= 8'd0;
      grp_fold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rec_cnt_q   <= rec_cnt_d;
      grp_valid_q <= grp_valid_d;
      grp_cnt_q   <= grp_cnt_d;
      grp_len_q   <= grp_len_d;
      grp_fold_q  <= grp_fold_d;
    end
  end

  always_comb begin
    ibuf_shift_en  = (state_q != ST_FLUSH) && !iu_hold && !iu_flush && (cand_cnt != 3'd0);
    ibuf_shift_len = ibuf_shift_en ? cand_len : 8'd0;

    state_d     = state_q;
    rec_cnt_d   = rec_cnt_q;
    grp_valid_d = grp_valid_q;
    grp_cnt_d   = grp_cnt_q;
    grp_len_d   = grp_len_q;
    grp_fold_d  = grp_fold_q;

    case (state_q)
      ST_RUN: begin
        if (iu_flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        rec_cnt_d = SINGLE_CNT_L;
        if (!iu_flush) state_d = (SINGLE_CNT_L != 3'd0) ? ST_RECOVER : ST_RUN;
      end
      ST_RECOVER: begin
        if (iu_flush) begin
          state_d = ST_FLUSH;
        end else if (ibuf_shift_en) begin
          rec_cnt_d = rec_cnt_q - 3'd1;
          if (rec_cnt_q <= 3'd1) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Hold freezes everything; flush or an empty slot only drops valid.
    if (ibuf_shift_en) begin
      grp_valid_d = 1'b1;
      grp_cnt_d   = cand_cnt;
      grp_len_d   = cand_len;
      grp_fold_d  = cand_cnt > 3'd1;
    end else if (iu_flush || !iu_hold) begin
      grp_valid_d = 1'b0;
    end
  end

  assign grp_valid = grp_valid_q;
  assign grp_cnt   = grp_cnt_q;
  assign grp_len   = grp_len_q;
  assign grp_fold  = grp_fold_q;

endmodule

// File: tb/tb_fold_ctl.sv
// Directed-vector bench for fold_ctl with hand-computed expectations.
module tb_fold_ctl;

  logic       clk = 1'b0;
  logic       reset_l;
  logic       fold_en;
  logic [5:0] type_0, type_1, type_2, type_3;
  logic [7:0] accum_len0, accum_len1, accum_len2, accum_len3;
  logic [3:0] ibuf_cnt;
  logic       iu_hold, iu_flush;
  logic       ibuf_shift_en;
  logic [7:0] ibuf_shift_len;
  logic       grp_valid;
  logic [2:0] grp_cnt;
  logic [7:0] grp_len;
  logic       grp_fold;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [5:0] T_LV  = 6'b000010;
  localparam logic [5:0] T_MEM = 6'b000100;
  localparam logic [5:0] T_BG1 = 6'b001000;
  localparam logic [5:0] T_BG2 = 6'b010000;

  always #5 clk = ~clk;

  fold_ctl #(.SINGLE_CNT(2)) dut (
    .clk            (clk),
    .reset_l        (reset_l),
    .fold_en        (fold_en),
    .type_0         (type_0),
    .type_1         (type_1),
    .type_2         (type_2),
    .type_3         (type_3),
    .accum_len0     (accum_len0),
    .accum_len1     (accum_len1),
    .accum_len2     (accum_len2),
    .accum_len3     (accum_len3),
    .ibuf_cnt       (ibuf_cnt),
    .iu_hold        (iu_hold),
    .iu_flush       (iu_flush),
    .ibuf_shift_en  (ibuf_shift_en),
    .ibuf_shift_len (ibuf_shift_len),
    .grp_valid      (grp_valid),
    .grp_cnt        (grp_cnt),
    .grp_len        (grp_len),
    .grp_fold       (grp_fold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grp(input string tag, input logic v, input logic [2:0] c,
                         input logic [7:0] l, input logic f);
    chk({tag, ".valid"}, 32'(grp_valid), 32'(v));
    chk({tag, ".cnt"},   32'(grp_cnt),   32'(c));
    chk({tag, ".len"},   32'(grp_len),   32'(l));
    chk({tag, ".fold"},  32'(grp_fold),  32'(f));
  endtask

  task automatic set_stream(input logic [3:0] fill);
    type_0 = T_LV; type_1 = T_LV; type_2 = T_BG2; type_3 = T_MEM;
    accum_len0 = 8'd1; accum_len1 = 8'd2; accum_len2 = 8'd3; accum_len3 = 8'd5;
    ibuf_cnt = fill;
  endtask

  initial begin
    reset_l = 1'b0; fold_en = 1'b1; iu_hold = 1'b0; iu_flush = 1'b0;
    set_stream(4'd0);
    #3;
    chk_grp("reset", 1'b0, 3'd0, 8'd0, 1'b0);
    #9 reset_l = 1'b1;
    cyc();
    chk("empty.valid", 32'(grp_valid), 32'd0);

    // Full four-instruction fold
    ibuf_cnt = 4'd7; #1;
    chk("fold4.shift_en",  32'(ibuf_shift_en),  32'd1);
    chk("fold4.shift_len", 32'(ibuf_shift_len), 32'd5);
    cyc();
    chk_grp("fold4", 1'b1, 3'd4, 8'd5, 1'b1);

    // Only three instructions' bytes present
    ibuf_cnt = 4'd4; #1;
    chk("fold3.shift_len", 32'(ibuf_shift_len), 32'd3);
    cyc();
    chk_grp("fold3", 1'b1, 3'd3, 8'd3, 1'b1);

    // First instruction incomplete
    accum_len0 = 8'd3; accum_len1 = 8'd4; accum_len2 = 8'd5; accum_len3 = 8'd6;
    ibuf_cnt = 4'd2; #1;
    chk("partial.shift_en",  32'(ibuf_shift_en),  32'd0);
    chk("partial.shift_len", 32'(ibuf_shift_len), 32'd0);
    cyc();
    chk_grp("partial", 1'b0, 3'd3, 8'd3, 1'b1);

    // BG1 MEM pair
    set_stream(4'd7); type_0 = T_BG1; type_1 = T_MEM; type_2 = T_LV; type_3 = T_LV;
    cyc();
    chk_grp("bg1mem", 1'b1, 3'd2, 8'd2, 1'b1);

    // NF-flagged type breaks the group
    set_stream(4'd7); type_1 = 6'b000011;
    cyc();
    chk_grp("nf", 1'b1, 3'd1, 8'd1, 1'b0);

    // Hold for three cycles
    set_stream(4'd7);
    cyc();
    chk_grp("prehold", 1'b1, 3'd4, 8'd5, 1'b1);
    iu_hold = 1'b1; ibuf_cnt = 4'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.shift_en", 32'(ibuf_shift_en), 32'd0);
      cyc();
      chk_grp("hold", 1'b1, 3'd4, 8'd5, 1'b1);
    end
    iu_hold = 1'b0;
    cyc();
    chk_grp("release", 1'b1, 3'd3, 8'd3, 1'b1);

    // Folding disabled
    set_stream(4'd7); fold_en = 1'b0; #1;
    chk("nofold.shift_len", 32'(ibuf_shift_len), 32'd1);
    cyc();
    chk_grp("nofold", 1'b1, 3'd1, 8'd1, 1'b0);
    fold_en = 1'b1;

    // Flush together with hold
    iu_flush = 1'b1; iu_hold = 1'b1; #1;
    chk("flush.shift_en", 32'(ibuf_shift_en), 32'd0);
    cyc();
    chk("flush.b1", 32'(grp_valid), 32'd0);
    iu_flush = 1'b0; iu_hold = 1'b0; #1;
    chk("flush.bubble_shift", 32'(ibuf_shift_en), 32'd0);
    cyc();
    chk("flush.b2", 32'(grp_valid), 32'd0);
    chk("rec.shift_len", 32'(ibuf_shift_len), 32'd1);
    cyc();
    chk_grp("rec1", 1'b1, 3'd1, 8'd1, 1'b0);
    cyc();
    chk_grp("rec2", 1'b1, 3'd1, 8'd1, 1'b0);
    cyc();
    chk_grp("resume", 1'b1, 3'd4, 8'd5, 1'b1);

    // Second flush inside RECOVER reloads the counter
    iu_flush = 1'b1;
    cyc();
    chk("fl2.b1", 32'(grp_valid), 32'd0);
    iu_flush = 1'b0;
    cyc();
    chk("fl2.b2", 32'(grp_valid), 32'd0);
    cyc();
    chk_grp("fl2.rec1", 1'b1, 3'd1, 8'd1, 1'b0);
    iu_flush = 1'b1;
    cyc();
    chk("fl3.b1", 32'(grp_valid), 32'd0);
    iu_flush = 1'b0;
    cyc();
    chk("fl3.b2", 32'(grp_valid), 32'd0);
    cyc();
    chk_grp("fl3.rec1", 1'b1, 3'd1, 8'd1, 1'b0);
    cyc();
    chk_grp("fl3.rec2", 1'b1, 3'd1, 8'd1, 1'b0);
    cyc();
    chk_grp("fl3.resume", 1'b1, 3'd4, 8'd5, 1'b1);

    // Asynchronous reset mid-recover
    iu_flush = 1'b1;
    cyc();
    iu_flush = 1'b0;
    cyc();
    cyc();
    chk_grp("prereset", 1'b1, 3'd1, 8'd1, 1'b0);
    #2 reset_l = 1'b0;
    #1;
    chk_grp("areset", 1'b0, 3'd0, 8'd0, 1'b0);
    chk("areset.shift_len", 32'(ibuf_shift_len), 32'd5);
    #2 reset_l = 1'b1;
    cyc();
    chk_grp("postreset", 1'b1, 3'd4, 8'd5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fold_ctl.md
# fold_ctl

Fold-group sequencer between the instruction buffer's fold type decoder and the decode stage.
- Each cycle it takes the fold types and cumulative byte lengths of the next four prospective instructions, plus the instruction-buffer fill level.
- It picks the largest legal fold group (1–4 instructions) whose bytes are all present, issues it to decode under a hold/flush handshake, and tells the instruction buffer how many bytes to shift out.
- After a pipeline flush it forces single-instruction issue for a programmable number of groups.

## Interface
Parameters:
- SINGLE_CNT, 2, number of groups issued unfolded after a flush (0 = no recovery window; max 7).

Ports:
- clk  in  1  core clock
- reset_l  in  1  asynchronous, active-low reset
- fold_en  in  1  folding enable; 0 = every group is one instruction
- type_0..type_3  in  6 each  fold types of prospective instructions 0..3; bit0 NF, bit1 LV, bit2 MEM, bit3 BG1, bit4 BG2, bit5 BR
- accum_len0..accum_len3  in  8 each  cumulative byte lengths: accum_lenN = len(inst0)+…+len(instN)
- ibuf_cnt  in  4  valid bytes in the instruction buffer (0..8)
- iu_hold  in  1  decode stage cannot accept a new group
- iu_flush  in  1  pipeline flush (taken branch or trap)
- ibuf_shift_en  out  1  combinational; shift the instruction buffer this cycle
- ibuf_shift_len  out  8  combinational; bytes to shift, equal to the selected group length
- grp_valid  out  1  registered; a group is presented to decode
- grp_cnt  out  3  registered; instructions in the group (1..4)
- grp_len  out  8  registered; bytes in the group
- grp_fold  out  1  registered; grp_cnt > 1

## Operation
Type qualification:
- A type with zero bits set, or with bit0 set, is treated as NF.

Candidate pattern match, highest priority first:
- 4: LV LV BG2 MEM.
- 3: LV LV BG2, LV BG2 MEM, LV BG1 MEM, LV LV BR.
- 2: LV BG2, LV BG1, LV MEM, LV BR, BG2 MEM, BG1 MEM.
- Otherwise 1.

Availability:
- A pattern of N instructions is taken only if accum_len(N-1) <= ibuf_cnt. Otherwise the next shorter matching pattern is tried.
- cand_cnt = 0 when accum_len0 > ibuf_cnt.
- When fold_en = 0 or state is RECOVER, cand_cnt is limited to 1.
- cand_len = accum_len(cand_cnt-1); cand_len = 0 when cand_cnt = 0.

States (2-bit, reset to RUN):
- RUN: issue allowed. On iu_flush, go to FLUSH.
- FLUSH: one-cycle bubble with no issue. Next state is RECOVER if SINGLE_CNT > 0, otherwise RUN. Load rec_cnt = SINGLE_CNT.
- RECOVER: issue is limited to 1 instruction. rec_cnt decrements on each issue; when the issue that brings it to 0 occurs, go to RUN. iu_flush goes to FLUSH and reloads the counter on exit.

Issue:
- ibuf_shift_en = (state != FLUSH) & !iu_hold & !iu_flush & (cand_cnt != 0).
- ibuf_shift_len = cand_len when ibuf_shift_en = 1, else 0.
- At the edge where ibuf_shift_en = 1: grp_valid <= 1, grp_cnt <= cand_cnt, grp_len <= cand_len, grp_fold <= (cand_cnt > 1).
- iu_hold = 1 and iu_flush = 0: all grp_* registers hold; no shift occurs.
- Not held, but no candidate, or state is FLUSH: grp_valid <= 0; grp_cnt and grp_len hold.

Simultaneous events:
- iu_flush takes priority over iu_hold: grp_valid <= 0 and no shift.

## Timing
- Reset (asynchronous, reset_l = 0): state = RUN, rec_cnt = 0, grp_valid = 0, grp_cnt = 0, grp_len = 0, grp_fold = 0. The combinational outputs follow their equations from these values.
- Latency: buffer contents present at cycle T produce registered grp_* at T+1. ibuf_shift_en and ibuf_shift_len are valid in cycle T.
- Flush at T: grp_valid = 0 at T+1 and T+2. The first possible post-flush issue is in cycle T+2, which presents grp_valid = 1 at T+3.
- Back-to-back issue every cycle is supported when iu_hold stays low.
- A reset asserted mid-hold or mid-recover returns to RUN immediately.

## Structure
- Shared package fold_pkg holds:
  - type bit indices: FT_NF, FT_LV, FT_MEM, FT_BG1, FT_BG2, FT_BR;
  - state encodings: ST_RUN, ST_FLUSH, ST_RECOVER.
- Sub-module fold_match (combinational) takes type_0..3, accum_len0..3, ibuf_cnt and a single-issue limit, and returns cand_cnt and cand_len.
- fold_ctl contains fold_match, the state machine, rec_cnt and the grp_* registers.

## Test plan
- Pattern and availability: types LV,LV,BG2,MEM, accum_len 1,2,3,5.
  - ibuf_cnt = 7: shift_en = 1, shift_len = 5; next cycle grp_cnt = 4, grp_len = 5, grp_fold = 1.
  - Same types, ibuf_cnt = 4: grp_cnt = 3, grp_len = 3.
- Partial fill: accum_len0 = 3, ibuf_cnt = 2 → shift_en = 0; next cycle grp_valid = 0.
- Hold: issue one group, then iu_hold = 1 for 3 cycles → grp_* stable and shift_en = 0 throughout; on release the next group issues.
- Flush with SINGLE_CNT = 2: iu_flush = 1 together with iu_hold = 1 in a folding stream.
  - Required: grp_valid = 0 for 2 cycles, then two groups with grp_cnt = 1, then folding resumes (grp_cnt = 4).
  - Repeat with a second flush inside RECOVER: the counter reloads.
- fold_en = 0 with LV,LV,BG2,MEM → grp_cnt = 1, grp_len = accum_len0.
- Reset: assert reset_l = 0 mid-RECOVER, asynchronously with respect to clk → all registered outputs 0 immediately; the first issue after release folds normally.
